rtc_i2c_reg_reader: RTL and testbench
=====================================

Name: rtc_i2c_reg_reader

Overview:
- I2C master that performs one single-byte random read from the RTC chip per request: START, device write address, register address, repeated START, device read address, one data byte, NACK, STOP.
- Sits directly upstream of the RTC time controller, which supplies a register address and consumes the returned byte.
- Replaces free-running polling with a start/busy/done handshake.
- Reports a missing acknowledge explicitly.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- SCL_HZ, 100000, I2C SCL frequency in Hz.
- DEV_ADDR, 7'h68, 7-bit I2C address of the RTC.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request pulse; ignored unless idle.
- reg_addr  input  8  RTC register address, sent MSB first, captured on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the transaction ends, with or without error.
- ack_error  output  1  valid with done; 1 = any address/register byte was NACKed.
- data_out  output  8  byte read; updated only on error-free done, otherwise held.
- i2c_scl  output  1  SCL; driven high/low, no clock stretching.
- i2c_sda  inout  1  open-drain SDA; drives 0 or Z, never drives 1.

Behaviour:
- Reset values:
  - busy=0, done=0, ack_error=0, data_out=8'h00.
  - i2c_scl=1, SDA released (Z).
  - State IDLE, divider and bit counters 0.
- Timing base:
  - Quarter-period tick every Q = CLK_HZ/(4*SCL_HZ) clocks (125 at defaults).
  - The divider runs only when not IDLE and restarts at 0 on an accepted start.
- Bit slot = 4 quarters:
  - q0: SCL low, SDA set to the bit.
  - q1: SCL rises.
  - q2: SCL high, SDA sampled.
  - q3: SCL falls.
- States:
  - IDLE: on start, capture reg_addr, set busy, go to START.
  - START: SDA low while SCL high (q1), then SCL low (q3); go to WR_DEV.
  - WR_DEV: 8 bits of {DEV_ADDR,1'b0}, MSB first; then ACK1.
  - ACK1: release SDA, sample at q2. 0 → WR_REG; 1 → set error flag, go to STOP.
  - WR_REG: 8 bits of the captured reg_addr; then ACK2 (same rule as ACK1, next state RESTART).
  - RESTART: SDA high with SCL low, SCL high, SDA low while SCL high, SCL low; go to WR_RD.
  - WR_RD: {DEV_ADDR,1'b1}; then ACK3 (same rule, next state RD_BYTE).
  - RD_BYTE: release SDA, shift in 8 bits at q2, MSB first; then NACK.
  - NACK: SDA released (reads as 1) for one bit slot; go to STOP.
  - STOP: SDA low with SCL low, SCL high, SDA released while SCL high; go to DONE.
  - DONE: for one clock, busy=0, done=1, ack_error=flag, and data_out=shift register if flag=0; go to IDLE.
- Transaction length without error: 1 (START) + 9+9 (WR_DEV, WR_REG, each with ACK) + 1 (RESTART) + 9 (WR_RD, ACK) + 9 (RD_BYTE, NACK) + 1 (STOP) = 39 bit slots.
  - At defaults this is 39*500 = 19500 clocks from start to done, ±2 clocks of pipeline.
  - The exact count is fixed by the implementation and must be documented in RTL; the bench uses a tolerance of ±4.
- Error path: any NACK aborts straight to STOP. No retry.
- start while busy: ignored, with no effect on the transaction or on the captured address.
- start in the same cycle as done: ignored. A new request is accepted from the cycle after done.
- reset mid-transaction (asynchronous): immediately SCL=1, SDA released, outputs to reset values. No STOP is generated; the bus recovers on the next START.
- SDA is sampled through a 2-flop synchronizer. Sample timing accounts for the 2-clock delay, since q2 lasts Q clocks.
- data_out holds its value between transactions.

Test Plan:
- Normal read: slave model at 0x68 returns 8'h59 for reg 8'h00; pulse start → SCL toggles at 100 kHz, bytes on bus 0xD0, 0x00, Sr, 0xD1; master NACKs, STOP; done=1 once, ack_error=0, data_out=8'h59, ~19500 clocks after start.
- Register sweep: reads of regs 0x00/0x01/0x02 returning 0x45/0x30/0x12 in turn → data_out matches each; busy low exactly between transactions.
- Absent device: slave never ACKs → STOP right after the first address byte; done with ack_error=1; data_out keeps its previous value (0x12).
- NACK on register byte: slave ACKs 0xD0 but NACKs reg 0x3F → STOP after the second byte; ack_error=1; no repeated START seen.
- Start while busy: second start pulse 1000 clocks after the first, with reg_addr=0x02 → ignored; only one transaction; bus shows reg 0x00.
- Reset mid-read: assert reset during RD_BYTE → same cycle SCL=1, SDA=Z, busy=0, data_out=0x00; a following start completes normally with 8'h59.

Source files
------------

// File: rtl/rtc_i2c_reg_reader_if.sv
// Request/response handshake between the RTC time controller and the I2C reader.
// Signals: start, reg_addr (requester to reader); busy, done, ack_error, data_out (reader to requester).
interface rtc_i2c_reg_reader_if;
   logic       start;
   logic [7:0] reg_addr;
   logic       busy;
   logic       done;
   logic       ack_error;
   logic [7:0] data_out;

   modport master (
      output start, reg_addr,
      input  busy, done, ack_error, data_out
   );

   modport slave (
      input  start, reg_addr,
      output busy, done, ack_error, data_out
   );
endinterface

// File: rtl/rtc_i2c_reg_reader.sv
// I2C master doing one single-byte random read from the RTC per start request.
// Ports: clock, reset (async, active high), host (handshake), i2c_scl, i2c_sda (open drain).
module rtc_i2c_reg_reader #(
   parameter int         CLK_HZ   = 50000000,
   parameter int         SCL_HZ   = 100000,
   parameter logic [6:0] DEV_ADDR = 7'h68
) (
   input  logic                 clock,
   input  logic                 reset,
   rtc_i2c_reg_reader_if.slave  host,
   output logic                 i2c_scl,
   inout  wire                  i2c_sda
);
   localparam int Q  = CLK_HZ / (4 * SCL_HZ);
   localparam int DW = (Q > 1) ? $clog2(Q) : 1;

   typedef enum logic [3:0] {
      IDLE, START, WR_DEV, ACK1, WR_REG, ACK2, RESTART,
      WR_RD, ACK3, RD_BYTE, NACK, STOP, DONE
   } state_t;

   state_t     state, state_n;
   logic [DW-1:0] div;
   logic [1:0] qtr;
   logic [2:0] bcnt;
   logic [7:0] tx, rx, reg_q, data_q;
   logic       err, scl_q, oe_q, scl_n, oe_n;
   logic [1:0] sda_sync;
   logic       tick, slot_end, sample, data_scl;

   // One bit slot is four quarters of Q clocks. A fault-free read is
   // 39 slots, so done is seen exactly 39*4*Q clocks after the edge
   // that accepts start (19500 at the default parameters).
   assign tick     = (div == DW'(Q - 1));
   assign slot_end = tick && (qtr == 2'd3);
   // Sample at the last clock of q2: the 2-flop synchronizer then
   // still reflects SDA from well inside the SCL-high window.
   assign sample   = tick && (qtr == 2'd2);
   assign data_scl = (qtr == 2'd1) || (qtr == 2'd2);

   assign i2c_sda        = oe_q ? 1'b0 : 1'bz;
   assign i2c_scl        = scl_q;
   assign host.busy      = (state != IDLE) && (state != DONE);
   assign host.done      = (state == DONE);
   assign host.ack_error = err;
   assign host.data_out  = data_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      scl_n   = 1'b1;
      oe_n    = 1'b0;
      unique case (state)
         IDLE: if (host.start) state_n = START;
         START: begin
            scl_n = (qtr != 2'd3);
            oe_n  = (qtr != 2'd0);
            if (slot_end) state_n = WR_DEV;
         end
         WR_DEV, WR_REG, WR_RD: begin
            scl_n = data_scl;
            oe_n  = ~tx[7];
            if (slot_end && bcnt == 3'd7) begin
               if (state == WR_DEV)      state_n = ACK1;
               else if (state == WR_REG) state_n = ACK2;
               else                      state_n = ACK3;
            end
         end
         ACK1: begin
            scl_n = data_scl;
            if (slot_end) state_n = err ? STOP : WR_REG;
         end
         ACK2: begin
            scl_n = data_scl;
            if (slot_end) state_n = err ? STOP : RESTART;
         end
         ACK3: begin
            scl_n = data_scl;
            if (slot_end) state_n = err ? STOP : RD_BYTE;
         end
         RESTART: begin
            scl_n = data_scl;
            oe_n  = qtr[1];
            if (slot_end) state_n = WR_RD;
         end
         RD_BYTE: begin
            scl_n = data_scl;
            if (slot_end && bcnt == 3'd7) state_n = NACK;
         end
         NACK: begin
            scl_n = data_scl;
            if (slot_end) state_n = STOP;
         end
         STOP: begin
            scl_n = (qtr != 2'd0);
            oe_n  = (qtr != 2'd3);
            if (slot_end) state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div      <= '0;
         qtr      <= 2'd0;
         bcnt     <= 3'd0;
         tx       <= 8'h00;
         rx       <= 8'h00;
         reg_q    <= 8'h00;
         data_q   <= 8'h00;
         err      <= 1'b0;
         scl_q    <= 1'b1;
         oe_q     <= 1'b0;
         sda_sync <= 2'b11;
      end else begin
         scl_q    <= scl_n;
         oe_q     <= oe_n;
         sda_sync <= {sda_sync[0], i2c_sda};
         if (state == IDLE) begin
            div  <= '0;
            qtr  <= 2'd0;
            bcnt <= 3'd0;
            if (host.start) begin
               reg_q <= host.reg_addr;
               tx    <= {DEV_ADDR, 1'b0};
               err   <= 1'b0;
            end
         end else begin
            div <= tick ? '0 : div + DW'(1);
            if (tick) qtr <= qtr + 2'd1;
         end
         if (sample) begin
            case (state)
               ACK1, ACK2, ACK3: if (sda_sync[1]) err <= 1'b1;
               RD_BYTE:          rx <= {rx[6:0], sda_sync[1]};
               default:          ;
            endcase
         end
         if (slot_end) begin
            case (state)
               WR_DEV, WR_REG, WR_RD, RD_BYTE: begin
                  bcnt <= bcnt + 3'd1;
                  tx   <= {tx[6:0], 1'b0};
               end
               ACK1:    tx <= reg_q;
               RESTART: tx <= {DEV_ADDR, 1'b1};
               STOP:    if (!err) data_q <= rx;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_rtc_i2c_reg_reader.sv
`timescale 1ns/1ps
module tb_rtc_i2c_reg_reader;
   localparam int CLK_HZ = 4000000;
   localparam int SCL_HZ = 100000;
   localparam int Q      = CLK_HZ / (4 * SCL_HZ);
   localparam int SLOT   = 4 * Q;
   localparam int FULL   = 39 * SLOT;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic scl;
   wire  sda;
   logic slv_drv = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc_cnt = 0;

   rtc_i2c_reg_reader_if bus ();

   pullup (sda);
   assign sda = slv_drv ? 1'b0 : 1'bz;

   rtc_i2c_reg_reader #(
      .CLK_HZ(CLK_HZ), .SCL_HZ(SCL_HZ), .DEV_ADDR(7'h68)
   ) dut (
      .clock(clock), .reset(reset), .host(bus),
      .i2c_scl(scl), .i2c_sda(sda)
   );

   always #125 clock = ~clock;
   always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

   // Slave model and bus monitor
   logic [7:0] mem [256];
   logic       present = 1'b1;
   int         nack_reg = -1;
   int         ev_q [$];
   int         nbits = 0;
   int         tidx = 0;
   logic [8:0] sh = '0;
   logic       rd_mode = 1'b0;
   logic       rd_pend = 1'b0;
   logic       ack;
   logic [7:0] ptr = 8'h00;
   logic [7:0] rd_byte = 8'h00;
   logic       p_scl = 1'b1;
   logic       p_sda = 1'b1;
   int         last_rise = 0;
   int         scl_period = 0;

   always @(scl or sda or reset) begin
      if (reset) begin
         slv_drv = 1'b0; rd_mode = 1'b0; rd_pend = 1'b0;
         nbits = 0; tidx = 0;
      end else if (scl !== p_scl) begin
         if (scl === 1'b1) begin
            if (tidx == 0 && nbits == 1) scl_period = cyc_cnt - last_rise;
            last_rise = cyc_cnt;
            sh = {sh[7:0], sda};
            nbits++;
            if (nbits == 9) begin
               ev_q.push_back({23'd0, sh[0], sh[8:1]});
               nbits = 0;
               tidx++;
            end
         end else begin
            if (nbits == 8 && !rd_mode) begin
               case (tidx)
                  0: ack = present && sh[7:0] == 8'hD0;
                  1: begin
                     ack = present && int'(sh[7:0]) != nack_reg;
                     ptr = sh[7:0];
                  end
                  2: begin
                     ack = present && sh[7:0] == 8'hD1;
                     rd_pend = ack;
                  end
                  default: ack = 1'b0;
               endcase
               slv_drv = ack;
            end else if (nbits == 0 && rd_pend) begin
               rd_pend = 1'b0;
               rd_mode = 1'b1;
               rd_byte = mem[ptr];
               slv_drv = !rd_byte[7];
            end else if (rd_mode && nbits >= 1 && nbits <= 7) begin
               slv_drv = !rd_byte[7-nbits];
            end else begin
               slv_drv = 1'b0;
               if (nbits == 8) rd_mode = 1'b0;
            end
         end
      end else if (sda !== p_sda && scl === 1'b1) begin
         if (sda === 1'b0) begin
            ev_q.push_back(512);
            nbits = 0;
         end else begin
            ev_q.push_back(513);
            nbits = 0; tidx = 0;
            rd_mode = 1'b0; rd_pend = 1'b0;
         end
      end
      p_scl = scl;
      p_sda = sda;
   end

   function automatic string log_str();
      string s = "";
      int v;
      foreach (ev_q[i]) begin
         v = ev_q[i];
         if (i != 0) s = {s, " "};
         if (v == 512)      s = {s, "S"};
         else if (v == 513) s = {s, "P"};
         else s = {s, $sformatf("%02x%s", v[7:0], v[8] ? "n" : "a")};
      end
      return s;
   endfunction

   task automatic run_read(
      input  logic [7:0] addr,
      input  int         extra_cyc,
      input  logic [7:0] extra_addr,
      input  bit         poke_done,
      output int         lat,
      output int         ndone,
      output int         busy_bad,
      output int         busy_after,
      output logic       err,
      output logic [7:0] d
   );
      lat = -1; ndone = 0; busy_bad = 0; busy_after = 0;
      err = 1'b0; d = 8'h00;
      ev_q.delete();
      scl_period = 0;
      @(negedge clock);
      bus.start = 1'b1; bus.reg_addr = addr;
      @(negedge clock);
      bus.start = 1'b0; bus.reg_addr = 8'hA5;
      for (int c = 1; c <= 4 * FULL; c++) begin
         bus.start = (c == extra_cyc);
         if (c == extra_cyc) bus.reg_addr = extra_addr;
         if (bus.done) begin
            ndone++;
            if (lat < 0) begin
               lat = c; err = bus.ack_error; d = bus.data_out;
               if (poke_done) bus.start = 1'b1;
            end
         end
         if (lat < 0 && !bus.done && !bus.busy) busy_bad++;
         if (lat >= 0 && bus.busy) busy_after++;
         if (lat >= 0 && c >= lat + 20) break;
         @(negedge clock);
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.reg_addr = 8'h00;
      repeat (3) @(negedge clock);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ack_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: busy=%b done=%b ack_error=%b want 000",
                  bus.busy, bus.done, bus.ack_error);
      end
      checks++;
      if (bus.data_out !== 8'h00) begin
         errors++; $display("FAIL reset_data: got %h want 00", bus.data_out);
      end
      checks++;
      if (scl !== 1'b1 || sda !== 1'b1) begin
         errors++; $display("FAIL reset_bus: scl=%b sda=%b want 1 1", scl, sda);
      end
      reset = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_normal_read();
      int lat, nd, bb, ba; logic e; logic [7:0] d;
      mem[0] = 8'h59; present = 1'b1; nack_reg = -1;
      run_read(8'h00, 0, 8'h00, 1'b0, lat, nd, bb, ba, e, d);
      checks++;
      if (lat < FULL - 4 || lat > FULL + 4) begin
         errors++; $display("FAIL normal_latency: got %0d want %0d+-4", lat, FULL);
      end
      checks++;
      if (nd !== 1) begin errors++; $display("FAIL normal_done_count: got %0d want 1", nd); end
      checks++;
      if (e !== 1'b0 || d !== 8'h59) begin
         errors++; $display("FAIL normal_result: err=%b data=%h want 0 59", e, d);
      end
      checks++;
      if (bb !== 0 || ba !== 0) begin
         errors++; $display("FAIL normal_busy: gaps=%0d after=%0d want 0 0", bb, ba);
      end
      checks++;
      if (log_str() != "S d0a 00a S d1a 59n P") begin
         errors++; $display("FAIL normal_bus: got '%s' want 'S d0a 00a S d1a 59n P'", log_str());
      end
      checks++;
      if (scl_period !== SLOT) begin
         errors++; $display("FAIL scl_period: got %0d want %0d", scl_period, SLOT);
      end
   endtask

   task automatic test_reg_sweep();
      int lat, nd, bb, ba; logic e; logic [7:0] d;
      logic [7:0] vals [3];
      string want;
      vals[0] = 8'h45; vals[1] = 8'h30; vals[2] = 8'h12;
      for (int i = 0; i < 3; i++) mem[i] = vals[i];
      for (int i = 0; i < 3; i++) begin
         run_read(8'(i), 0, 8'h00, i == 2, lat, nd, bb, ba, e, d);
         checks++;
         if (e !== 1'b0 || d !== vals[i] || nd !== 1) begin
            errors++;
            $display("FAIL sweep_%0d: err=%b data=%h done=%0d want 0 %h 1", i, e, d, nd, vals[i]);
         end
         checks++;
         if (bb !== 0 || ba !== 0) begin
            errors++; $display("FAIL sweep_busy_%0d: gaps=%0d after=%0d want 0 0", i, bb, ba);
         end
         want = $sformatf("S d0a %02xa S d1a %02xn P", i, vals[i]);
         checks++;
         if (log_str() != want) begin
            errors++; $display("FAIL sweep_bus_%0d: got '%s' want '%s'", i, log_str(), want);
         end
      end
   endtask

   task automatic test_absent_device();
      int lat, nd, bb, ba; logic e; logic [7:0] d;
      present = 1'b0;
      run_read(8'h00, 0, 8'h00, 1'b0, lat, nd, bb, ba, e, d);
      present = 1'b1;
      checks++;
      if (e !== 1'b1 || d !== 8'h12 || nd !== 1) begin
         errors++; $display("FAIL absent_result: err=%b data=%h done=%0d want 1 12 1", e, d, nd);
      end
      checks++;
      if (log_str() != "S d0n P") begin
         errors++; $display("FAIL absent_bus: got '%s' want 'S d0n P'", log_str());
      end
      checks++;
      if (lat < 11 * SLOT - 4 || lat > 11 * SLOT + 4) begin
         errors++; $display("FAIL absent_latency: got %0d want %0d+-4", lat, 11 * SLOT);
      end
   endtask

   task automatic test_nack_register();
      int lat, nd, bb, ba; logic e; logic [7:0] d;
      nack_reg = 8'h3F;
      run_read(8'h3F, 0, 8'h00, 1'b0, lat, nd, bb, ba, e, d);
      nack_reg = -1;
      checks++;
      if (e !== 1'b1 || d !== 8'h12 || nd !== 1) begin
         errors++; $display("FAIL nackreg_result: err=%b data=%h done=%0d want 1 12 1", e, d, nd);
      end
      checks++;
      if (log_str() != "S d0a 3fn P") begin
         errors++; $display("FAIL nackreg_bus: got '%s' want 'S d0a 3fn P'", log_str());
      end
      checks++;
      if (lat < 20 * SLOT - 4 || lat > 20 * SLOT + 4) begin
         errors++; $display("FAIL nackreg_latency: got %0d want %0d+-4", lat, 20 * SLOT);
      end
   endtask

   task automatic test_start_while_busy();
      int lat, nd, bb, ba; logic e; logic [7:0] d;
      mem[0] = 8'h59; mem[2] = 8'h12;
      run_read(8'h00, 500, 8'h02, 1'b0, lat, nd, bb, ba, e, d);
      checks++;
      if (nd !== 1 || ba !== 0) begin
         errors++; $display("FAIL busy_start_count: done=%0d busy_after=%0d want 1 0", nd, ba);
      end
      checks++;
      if (e !== 1'b0 || d !== 8'h59) begin
         errors++; $display("FAIL busy_start_data: err=%b data=%h want 0 59", e, d);
      end
      checks++;
      if (log_str() != "S d0a 00a S d1a 59n P") begin
         errors++; $display("FAIL busy_start_bus: got '%s' want 'S d0a 00a S d1a 59n P'", log_str());
      end
   endtask

   task automatic test_reset_mid_read();
      int lat, nd, bb, ba; logic e; logic [7:0] d;
      ev_q.delete();
      @(negedge clock);
      bus.start = 1'b1; bus.reg_addr = 8'h00;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (31 * SLOT) @(negedge clock);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++; $display("FAIL midread_busy: got %b want 1", bus.busy);
      end
      #37 reset = 1'b1;
      #1;
      checks++;
      if (scl !== 1'b1 || sda !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL midread_reset_bus: scl=%b sda=%b busy=%b done=%b want 1 1 0 0",
                  scl, sda, bus.busy, bus.done);
      end
      checks++;
      if (bus.data_out !== 8'h00 || bus.ack_error !== 1'b0) begin
         errors++;
         $display("FAIL midread_reset_data: data=%h err=%b want 00 0", bus.data_out, bus.ack_error);
      end
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      run_read(8'h00, 0, 8'h00, 1'b0, lat, nd, bb, ba, e, d);
      checks++;
      if (e !== 1'b0 || d !== 8'h59 || nd !== 1) begin
         errors++; $display("FAIL midread_recover: err=%b data=%h done=%0d want 0 59 1", e, d, nd);
      end
      checks++;
      if (log_str() != "S d0a 00a S d1a 59n P") begin
         errors++; $display("FAIL midread_bus: got '%s' want 'S d0a 00a S d1a 59n P'", log_str());
      end
   endtask

   initial begin
      test_reset();
      test_normal_read();
      test_reg_sweep();
      test_absent_device();
      test_nack_register();
      test_start_while_busy();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
